// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the datapath.
// master: controller side (drives strobes/selects); slave: datapath side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_wdata_pc;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       trap;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
        output mem_wdata_pc, reg_write, reg_dst, mem_to_reg,
        output alu_src_a, alu_src_b, alu_op, trap, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write,
        input  mem_wdata_pc, reg_write, reg_dst, mem_to_reg,
        input  alu_src_a, alu_src_b, alu_op, trap, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle FSM controller for the extended MIPS datapath (R/lw/sw/beq,
// jmem, bmem, js, pctoreg). Ports: clk, reset (async high), bus (master).
module multicycle_control #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int WAIT_LIMIT    = 15,
    parameter int WAIT_W        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MADDR   = 4'd3,
        S_MREAD   = 4'd4,
        S_MWB     = 4'd5,
        S_MWRITE  = 4'd6,
        S_REXEC   = 4'd7,
        S_RWB     = 4'd8,
        S_BEQ     = 4'd9,
        S_JMEMPC  = 4'd10,
        S_BMEMCMP = 4'd11,
        S_JSSTORE = 4'd12,
        S_PCWB    = 4'd13,
        S_TRAP    = 4'd15
    } state_e;

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    state_e            done_next;
    logic              done;
    logic              is_mem_state;

    logic is_rtype, is_jmem, is_pctoreg, is_ralu;
    logic is_lw, is_sw, is_beq, is_bmem, is_js;

    assign done       = MEM_HANDSHAKE ? bus.mem_ready : 1'b1;
    assign is_rtype   = (bus.opcode == 6'h00);
    assign is_jmem    = is_rtype && (bus.funct == 6'h2D);
    assign is_pctoreg = is_rtype && (bus.funct == 6'h16);
    assign is_ralu    = is_rtype && !is_jmem && !is_pctoreg;
    assign is_lw      = (bus.opcode == 6'h23);
    assign is_sw      = (bus.opcode == 6'h2B);
    assign is_beq     = (bus.opcode == 6'h04);
    assign is_bmem    = (bus.opcode == 6'h14);
    assign is_js      = (bus.opcode == 6'h13);

    assign is_mem_state = (state_q == S_FETCH) || (state_q == S_MREAD) ||
                          (state_q == S_MWRITE) || (state_q == S_JSSTORE);

    // Successor of a memory state once its access completes.
    always_comb begin
        done_next = S_FETCH;
        case (state_q)
            S_FETCH: done_next = S_DECODE;
            S_MREAD: begin
                unique case (1'b1)
                    is_lw:   done_next = S_MWB;
                    is_jmem: done_next = S_JMEMPC;
                    is_bmem: done_next = S_BMEMCMP;
                    default: done_next = S_TRAP;
                endcase
            end
            default: done_next = S_FETCH;
        endcase
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        if (is_mem_state) begin
            // A completing access beats the timeout in the same cycle.
            if (done) begin
                state_d = done_next;
            end else if (wait_q == LIMIT) begin
                state_d = S_TRAP;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_FETCH;
                S_DECODE: begin
                    unique case (1'b1)
                        is_ralu:    state_d = S_REXEC;
                        is_pctoreg: state_d = S_PCWB;
                        is_jmem, is_lw, is_sw, is_bmem, is_js:
                                    state_d = S_MADDR;
                        is_beq:     state_d = S_BEQ;
                        default:    state_d = S_TRAP;
                    endcase
                end
                S_MADDR: begin
                    unique case (1'b1)
                        is_lw, is_bmem, is_jmem: state_d = S_MREAD;
                        is_sw:   state_d = S_MWRITE;
                        is_js:   state_d = S_JSSTORE;
                        default: state_d = S_TRAP;
                    endcase
                end
                S_TRAP:  state_d = S_TRAP;
                S_MWB, S_RWB, S_BEQ, S_JMEMPC, S_BMEMCMP, S_PCWB,
                S_REXEC: state_d = (state_q == S_REXEC) ? S_RWB : S_FETCH;
                default: state_d = S_TRAP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Outputs decode the state flop so reset clears them asynchronously.
    always_comb begin
        bus.pc_write     = 1'b0;
        bus.pc_src       = 2'b00;
        bus.ir_write     = 1'b0;
        bus.i_or_d       = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_wdata_pc = 1'b0;
        bus.reg_write    = 1'b0;
        bus.reg_dst      = 1'b0;
        bus.mem_to_reg   = 2'b00;
        bus.alu_src_a    = 1'b0;
        bus.alu_src_b    = 2'b00;
        bus.alu_op       = 2'b00;
        bus.trap         = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = done;
                bus.pc_write  = done;
            end
            S_DECODE: bus.alu_src_b = 2'b11;
            S_MADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = is_jmem ? 2'b00 : 2'b10;
            end
            S_MREAD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
            end
            S_MWRITE: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_REXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b01;
                bus.pc_write  = bus.zero;
            end
            S_JMEMPC: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b11;
            end
            S_BMEMCMP: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b01;
                bus.pc_src    = 2'b11;
                bus.pc_write  = bus.zero;
            end
            S_JSSTORE: begin
                bus.mem_write    = 1'b1;
                bus.i_or_d       = 1'b1;
                bus.mem_wdata_pc = 1'b1;
                bus.pc_src       = 2'b10;
                bus.pc_write     = done;
            end
            S_PCWB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.mem_to_reg = 2'b10;
            end
            S_TRAP:  bus.trap = 1'b1;
            default: ;
        endcase
    end

    assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: expected state traces are
// built per instruction class and outputs come from a per-state table.
module tb_multicycle_control;
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MADDR = 3;
    localparam int S_MREAD = 4, S_MWB = 5, S_MWRITE = 6, S_REXEC = 7;
    localparam int S_RWB = 8, S_BEQ = 9, S_JMEMPC = 10, S_BMEMCMP = 11;
    localparam int S_JSSTORE = 12, S_PCWB = 13, S_TRAP = 15;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3;
    localparam int K_JMEM = 4, K_BMEM = 5, K_JS = 6, K_PCR = 7;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    multicycle_control_if ifa ();
    multicycle_control_if ifb ();

    multicycle_control #(.MEM_HANDSHAKE(1'b1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.master)
    );
    multicycle_control #(.MEM_HANDSHAKE(1'b0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.master)
    );

    logic [17:0] ctl_a, ctl_b;
    assign ctl_a = {ifa.pc_write, ifa.pc_src, ifa.ir_write, ifa.i_or_d,
                    ifa.mem_read, ifa.mem_write, ifa.mem_wdata_pc,
                    ifa.reg_write, ifa.reg_dst, ifa.mem_to_reg,
                    ifa.alu_src_a, ifa.alu_src_b, ifa.alu_op, ifa.trap};
    assign ctl_b = {ifb.pc_write, ifb.pc_src, ifb.ir_write, ifb.i_or_d,
                    ifb.mem_read, ifb.mem_write, ifb.mem_wdata_pc,
                    ifb.reg_write, ifb.reg_dst, ifb.mem_to_reg,
                    ifb.alu_src_a, ifb.alu_src_b, ifb.alu_op, ifb.trap};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Control word each state must present, straight from the state table.
    function automatic logic [17:0] exp_ctl(input int st, input bit done,
                                            input bit z, input bit jm);
        logic pcw, irw, iod, mr, mw, wpc, rw, rd, asa, tr;
        logic [1:0] pcs, m2r, asb, aop;
        {pcw, pcs, irw, iod, mr, mw, wpc, rw, rd, m2r, asa, asb, aop, tr} = '0;
        case (st)
            S_FETCH:   begin mr = 1; asb = 2'b01; irw = done; pcw = done; end
            S_DECODE:  asb = 2'b11;
            S_MADDR:   begin asa = 1; asb = jm ? 2'b00 : 2'b10; end
            S_MREAD:   begin mr = 1; iod = 1; end
            S_MWB:     begin rw = 1; m2r = 2'b01; end
            S_MWRITE:  begin mw = 1; iod = 1; end
            S_REXEC:   begin asa = 1; aop = 2'b10; end
            S_RWB:     begin rw = 1; rd = 1; end
            S_BEQ:     begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = z; end
            S_JMEMPC:  begin pcw = 1; pcs = 2'b11; end
            S_BMEMCMP: begin asa = 1; aop = 2'b01; pcs = 2'b11; pcw = z; end
            S_JSSTORE: begin mw = 1; iod = 1; wpc = 1; pcs = 2'b10; pcw = done; end
            S_PCWB:    begin rw = 1; rd = 1; m2r = 2'b10; end
            S_TRAP:    tr = 1;
            default:   ;
        endcase
        return {pcw, pcs, irw, iod, mr, mw, wpc, rw, rd, m2r, asa, asb, aop, tr};
    endfunction

    // Called just after a negedge: drive inputs, sample, advance one cycle.
    task automatic step(input int st, input bit rdy, input bit z, input bit jm);
        ifa.mem_ready = rdy;
        ifa.zero      = z;
        #1;
        check($sformatf("state_s%0d", st), 32'(ifa.state), st);
        check($sformatf("ctl_s%0d", st), 32'(ctl_a), 32'(exp_ctl(st, rdy, z, jm)));
        @(negedge clk);
    endtask

    task automatic mem_phase(input int st, input int waits, input bit z,
                             input bit jm);
        for (int i = 0; i < waits; i++) step(st, 1'b0, z, jm);
        step(st, 1'b1, z, jm);
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input int kind, input int fw, input int mw,
                             input bit z);
        bit jm;
        logic [5:0] f;
        f = 6'($urandom_range(0, 63));
        if (f == 6'h2D || f == 6'h16) f = 6'h20;
        ifa.funct = 6'($urandom_range(0, 63));
        case (kind)
            K_R:    begin ifa.opcode = 6'h00; ifa.funct = f; end
            K_LW:   ifa.opcode = 6'h23;
            K_SW:   ifa.opcode = 6'h2B;
            K_BEQ:  ifa.opcode = 6'h04;
            K_JMEM: begin ifa.opcode = 6'h00; ifa.funct = 6'h2D; end
            K_BMEM: ifa.opcode = 6'h14;
            K_JS:   ifa.opcode = 6'h13;
            default: begin ifa.opcode = 6'h00; ifa.funct = 6'h16; end
        endcase
        jm = (kind == K_JMEM);
        mem_phase(S_FETCH, fw, z, jm);
        step(S_DECODE, rb(), z, jm);
        case (kind)
            K_R:    begin step(S_REXEC, rb(), z, jm); step(S_RWB, rb(), z, jm); end
            K_LW:   begin step(S_MADDR, rb(), z, jm); mem_phase(S_MREAD, mw, z, jm);
                          step(S_MWB, rb(), z, jm); end
            K_SW:   begin step(S_MADDR, rb(), z, jm); mem_phase(S_MWRITE, mw, z, jm); end
            K_BEQ:  step(S_BEQ, rb(), z, jm);
            K_JMEM: begin step(S_MADDR, rb(), z, jm); mem_phase(S_MREAD, mw, z, jm);
                          step(S_JMEMPC, rb(), z, jm); end
            K_BMEM: begin step(S_MADDR, rb(), z, jm); mem_phase(S_MREAD, mw, z, jm);
                          step(S_BMEMCMP, rb(), z, jm); end
            K_JS:   begin step(S_MADDR, rb(), z, jm); mem_phase(S_JSSTORE, mw, z, jm); end
            default: step(S_PCWB, rb(), z, jm);
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_state", 32'(ifa.state), S_IDLE);
        check("rst_ctl", 32'(ctl_a), 0);
        @(negedge clk);
        reset = 1'b0;
        step(S_IDLE, rb(), 1'b0, 1'b0);
    endtask

    initial begin
        int seq_b[7];
        reset = 1'b1;
        ifa.opcode = 6'h00; ifa.funct = 6'h20;
        ifa.zero = 1'b0; ifa.mem_ready = 1'b0;
        ifb.opcode = 6'h23; ifb.funct = 6'h00;
        ifb.zero = 1'b0; ifb.mem_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Directed cases first, then a random instruction mix.
        run_instr(K_LW, 0, 2, 1'b0);
        run_instr(K_BMEM, 0, 0, 1'b1);
        run_instr(K_BMEM, 1, 0, 1'b0);
        run_instr(K_JS, 0, 0, 1'b0);
        run_instr(K_BEQ, 0, 0, 1'b1);
        for (int n = 0; n < 60; n++)
            run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 5)), rb());

        // Reset in the middle of a stalled store.
        ifa.opcode = 6'h2B;
        mem_phase(S_FETCH, 0, 1'b0, 1'b0);
        step(S_DECODE, 1'b0, 1'b0, 1'b0);
        step(S_MADDR, 1'b0, 1'b0, 1'b0);
        ifa.mem_ready = 1'b0;
        #1 check("mw_before_rst", 32'(ifa.mem_write), 1);
        #2 reset = 1'b1;
        #1 check("mw_after_rst", 32'(ifa.mem_write), 0);
        check("state_after_rst", 32'(ifa.state), S_IDLE);
        @(negedge clk);
        reset = 1'b0;
        step(S_IDLE, 1'b0, 1'b0, 1'b0);
        run_instr(K_SW, 0, 1, 1'b0);

        // Fetch never completes: 16 waiting cycles, then sticky trap.
        for (int i = 0; i < 16; i++) step(S_FETCH, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(S_TRAP, rb(), rb(), 1'b0);
        do_reset();

        // Illegal opcode traps from decode.
        ifa.opcode = 6'h3F;
        mem_phase(S_FETCH, 0, 1'b0, 1'b0);
        step(S_DECODE, 1'b1, 1'b0, 1'b0);
        step(S_TRAP, 1'b1, 1'b0, 1'b0);
        step(S_TRAP, 1'b0, 1'b1, 1'b0);

        // No-handshake instance: lw runs straight through with ready low.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seq_b = '{S_IDLE, S_FETCH, S_DECODE, S_MADDR, S_MREAD, S_MWB, S_FETCH};
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("b_state%0d", i), 32'(ifb.state), seq_b[i]);
            check($sformatf("b_ctl%0d", i), 32'(ctl_b),
                  32'(exp_ctl(seq_b[i], 1'b1, 1'b0, 1'b0)));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
